set_key_conditioner: RTL and testbench
======================================

Name: set_key_conditioner

Overview:
- Upstream stage of the time-of-day counter. Conditions the two raw, active-low pushbuttons used for setting the clock: the minute-set key and the hour-set key.
- Each key gets a synchronizer, a debouncer and hold-to-repeat logic.
- Produces single-cycle increment pulses that drive the counter's incrementMinutes and incrementHours inputs directly.
- Also exports the debounced key levels for LEDs or other status indication.

Parameters:
- DEBOUNCE_CYC, 1_000_000: number of stable clocks (20 ms at 50 MHz) required to accept a press or a release.
- HOLD_CYC, 25_000_000: clocks a key must stay held after the first pulse before auto-repeat starts (500 ms).
- REPEAT_CYC, 10_000_000: clocks between auto-repeat pulses (200 ms).
- REPEAT_EN, 1: 1 enables auto-repeat; 0 gives exactly one pulse per press.

Ports:
- clk_50MHz, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- keyMinutes_n, input, 1: raw minute-set button, asynchronous; 0 = pressed.
- keyHours_n, input, 1: raw hour-set button, asynchronous; 0 = pressed.
- incrementMinutes, output, 1: one-clock pulse for each accepted minute increment.
- incrementHours, output, 1: one-clock pulse for each accepted hour increment.
- minutesHeld, output, 1: debounced level of the minute key; 1 = pressed.
- hoursHeld, output, 1: debounced level of the hour key; 1 = pressed.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all outputs 0;
  - synchronizer flops preset to 1 (released);
  - each channel enters ARM with its timer at 0.
- Channels are fully independent. Simultaneous presses each produce their own pulses, in the same cycle if their timing coincides.
- Synchronizer: 2 flops. pressed_s = inverted output of the second flop.
- Timer: one per channel. Width = ceiling(log2(max(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC))) + 1. It saturates and never wraps.
- States per channel:
  - ARM: waits until pressed_s has been 0 for DEBOUNCE_CYC consecutive clocks, then goes to IDLE. A press resets the timer. This stops a key held through reset from generating a pulse.
  - IDLE: when pressed_s = 1, go to DEB_PRESS with timer = 0.
  - DEB_PRESS: if pressed_s = 0, return to IDLE (glitch rejected, no pulse). When the timer reaches DEBOUNCE_CYC-1 with pressed_s = 1: pulse for 1 clock, set held = 1, go to HOLD with timer = 0.
  - HOLD: if pressed_s = 0, go to DEB_REL with timer = 0. When the timer reaches HOLD_CYC-1 and REPEAT_EN = 1: pulse, go to REPEAT with timer = 0. With REPEAT_EN = 0, stay in HOLD with the timer saturated.
  - REPEAT: if pressed_s = 0, go to DEB_REL. When the timer reaches REPEAT_CYC-1: pulse, timer = 0, stay in REPEAT. The repeat period is exactly REPEAT_CYC clocks.
  - DEB_REL: if pressed_s = 1, timer = 0 and stay (no new pulse). When the timer reaches DEBOUNCE_CYC-1 with pressed_s = 0: held = 0, go to IDLE.
- Pulse width is exactly 1 clock. Pulses on one channel are never back-to-back.
- Latency: a clean press sampled at edge k gives a pulse high during the cycle after edge k+2+DEBOUNCE_CYC. Allow ±1 clock for synchronizer metastability.
- held rises in the same clock as the first pulse. It falls DEBOUNCE_CYC+2 clocks after a clean release.
- Reset asserted mid-operation:
  - outputs drop immediately (asynchronous);
  - any pending pulse is lost;
  - after release the channel passes through ARM again.
- Edge cases:
  - A press shorter than DEBOUNCE_CYC produces no pulse.
  - Release bounce never produces a pulse.

Decomposition:
- Shared package/include holds:
  - state encodings ARM, IDLE, DEB_PRESS, HOLD, REPEAT, DEB_REL (3 bits);
  - the timer-width function;
  - default timing constants.
- Sub-module key_channel (synchronizer + FSM + timer, one key) is instantiated twice. The top level only wires it.

Test Plan (bench overrides DEBOUNCE_CYC=10, HOLD_CYC=50, REPEAT_CYC=20):
- Clean press (low at edge 0, held 30 clocks) -> exactly one incrementMinutes pulse, at clock 12±1. minutesHeld is 1 from the same clock and falls 12±1 clocks after release.
- Glitchy press (5 clocks low, 2 high, 3 low, then released) -> no pulse and minutesHeld stays 0. Release bounce after a valid press (5×2-clock toggles) -> no extra pulse.
- Hold keyHours_n low for 200 clocks -> pulses at ~12, 62, 82, 102, …: 8 pulses in total, spacing exactly 20. With REPEAT_EN=0 -> exactly 1 pulse.
- Both keys pressed in the same cycle for 30 clocks -> incrementMinutes and incrementHours each pulse once, in the same clock.
- Key held low through reset release -> no pulse. After release plus 10 clocks, a new press is pulsed normally.
- Reset asserted in HOLD and in REPEAT -> all outputs are 0 within the same clock (asynchronous), and no pulse appears after release.

Source files
------------

// File: rtl/set_key_conditioner_pkg.sv
// Shared definitions for the set-key conditioner: channel state encoding,
// default timing constants and the timer-width helper.
package set_key_conditioner_pkg;

  localparam int unsigned STATE_W = 3;

  // Per-channel conditioning state
  typedef enum logic [STATE_W-1:0] {
    ARM       = 3'd0,
    IDLE      = 3'd1,
    DEB_PRESS = 3'd2,
    HOLD      = 3'd3,
    REPEAT    = 3'd4,
    DEB_REL   = 3'd5
  } key_state_e;

  // Defaults for a 50 MHz clock: 20 ms debounce, 500 ms hold, 200 ms repeat
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int unsigned DEF_HOLD_CYC     = 25_000_000;
  localparam int unsigned DEF_REPEAT_CYC   = 10_000_000;
  localparam int unsigned DEF_REPEAT_EN    = 1;

  // Timer must hold the largest terminal count with one spare bit so that
  // saturation never aliases onto a terminal value.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/set_key_conditioner_key_channel.sv
// One set-key channel: reset-release synchronizer, 2-flop key synchronizer,
// debounce / hold / auto-repeat FSM with a saturating timer.
module set_key_conditioner_key_channel
  import set_key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int unsigned REPEAT_EN    = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse,
  output logic held
);

  localparam int unsigned TW = timer_width(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC);
  localparam logic [TW-1:0] DEB_LAST = TW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] RPT_LAST = TW'(REPEAT_CYC - 1);
  localparam logic [TW-1:0] TMR_MAX = '1;
  localparam logic RPT_ON = (REPEAT_EN != 0);

  logic rst_meta_q, rst_sync_q;
  logic rst_int_n;
  logic sync1_q, sync2_q;
  logic pressed_s;

  key_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] timer_inc;
  logic pulse_q, pulse_d;
  logic held_q, held_d;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_int_n = rst_sync_q;

  // Key synchronizer, preset to "released"
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;
  assign timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + TW'(1);

  // State, timer and output registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ARM;
      timer_q <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARM:       if (!pressed_s && timer_q == DEB_LAST) state_d = IDLE;
      IDLE:      if (pressed_s) state_d = DEB_PRESS;
      DEB_PRESS: begin
        if (!pressed_s)                state_d = IDLE;
        else if (timer_q == DEB_LAST)  state_d = HOLD;
      end
      HOLD: begin
        if (!pressed_s)                          state_d = DEB_REL;
        else if (RPT_ON && timer_q == HOLD_LAST) state_d = REPEAT;
      end
      REPEAT:    if (!pressed_s) state_d = DEB_REL;
      DEB_REL:   if (!pressed_s && timer_q == DEB_LAST) state_d = IDLE;
      default:   state_d = ARM;
    endcase
  end

  // Timer, pulse and held-level logic
  always_comb begin
    timer_d = timer_inc;
    pulse_d = 1'b0;
    held_d  = held_q;
    case (state_q)
      ARM: begin
        if (pressed_s || timer_q == DEB_LAST) timer_d = '0;
      end
      IDLE: timer_d = '0;
      DEB_PRESS: begin
        if (!pressed_s) begin
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          pulse_d = 1'b1;
          held_d  = 1'b1;
          timer_d = '0;
        end
      end
      HOLD: begin
        if (!pressed_s) begin
          timer_d = '0;
        end else if (RPT_ON && timer_q == HOLD_LAST) begin
          pulse_d = 1'b1;
          timer_d = '0;
        end
      end
      REPEAT: begin
        if (!pressed_s) begin
          timer_d = '0;
        end else if (timer_q == RPT_LAST) begin
          pulse_d = 1'b1;
          timer_d = '0;
        end
      end
      DEB_REL: begin
        if (pressed_s) begin
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          held_d  = 1'b0;
          timer_d = '0;
        end
      end
      default: begin
        timer_d = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  assign pulse = pulse_q;
  assign held  = held_q;

endmodule

// File: rtl/set_key_conditioner.sv
// Set-key conditioner top: one independent conditioning channel per key,
// feeding the time-of-day counter's increment inputs.
module set_key_conditioner
  import set_key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int unsigned REPEAT_EN    = DEF_REPEAT_EN
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic keyMinutes_n,
  input  logic keyHours_n,
  output logic incrementMinutes,
  output logic incrementHours,
  output logic minutesHeld,
  output logic hoursHeld
);

  set_key_conditioner_key_channel #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC),
    .REPEAT_EN    (REPEAT_EN)
  ) u_key_minutes (
    .clk   (clk_50MHz),
    .rst_n (reset),
    .key_n (keyMinutes_n),
    .pulse (incrementMinutes),
    .held  (minutesHeld)
  );

  set_key_conditioner_key_channel #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .REPEAT_CYC   (REPEAT_CYC),
    .REPEAT_EN    (REPEAT_EN)
  ) u_key_hours (
    .clk   (clk_50MHz),
    .rst_n (reset),
    .key_n (keyHours_n),
    .pulse (incrementHours),
    .held  (hoursHeld)
  );

endmodule

// File: tb/tb_set_key_conditioner.sv
// Directed bench for set_key_conditioner with short timing constants.
module tb_set_key_conditioner;

  localparam int unsigned DC = 10;
  localparam int unsigned HC = 50;
  localparam int unsigned RC = 20;

  logic clk = 1'b0;
  logic reset;
  logic key_min_n, key_hr_n;
  logic inc_min, inc_hr, min_held, hr_held;
  logic nr_key_min_n, nr_key_hr_n;
  logic nr_inc_min, nr_inc_hr, nr_min_held, nr_hr_held;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  int min_q[$];
  int hr_q[$];
  int nr_hr_q[$];
  int min_rise_q[$];
  int min_fall = -1;
  int both_cnt = 0;
  int b2b_cnt = 0;
  int nr_min_cnt = 0;
  logic min_held_prev = 1'b0;
  logic min_pulse_prev = 1'b0;
  logic hr_pulse_prev = 1'b0;

  set_key_conditioner #(
    .DEBOUNCE_CYC (DC), .HOLD_CYC (HC), .REPEAT_CYC (RC), .REPEAT_EN (1)
  ) dut (
    .clk_50MHz        (clk),
    .reset            (reset),
    .keyMinutes_n     (key_min_n),
    .keyHours_n       (key_hr_n),
    .incrementMinutes (inc_min),
    .incrementHours   (inc_hr),
    .minutesHeld      (min_held),
    .hoursHeld        (hr_held)
  );

  set_key_conditioner #(
    .DEBOUNCE_CYC (DC), .HOLD_CYC (HC), .REPEAT_CYC (RC), .REPEAT_EN (0)
  ) dut_nr (
    .clk_50MHz        (clk),
    .reset            (reset),
    .keyMinutes_n     (nr_key_min_n),
    .keyHours_n       (nr_key_hr_n),
    .incrementMinutes (nr_inc_min),
    .incrementHours   (nr_inc_hr),
    .minutesHeld      (nr_min_held),
    .hoursHeld        (nr_hr_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record pulse and held-edge cycle numbers, sampled mid-cycle
  always @(negedge clk) begin
    if (inc_min) min_q.push_back(cyc);
    if (inc_hr) hr_q.push_back(cyc);
    if (nr_inc_hr) nr_hr_q.push_back(cyc);
    if (nr_inc_min) nr_min_cnt++;
    if (inc_min && inc_hr) both_cnt++;
    if ((inc_min && min_pulse_prev) || (inc_hr && hr_pulse_prev)) b2b_cnt++;
    if (min_held && !min_held_prev) min_rise_q.push_back(cyc);
    if (!min_held && min_held_prev) min_fall = cyc;
    min_held_prev  = min_held;
    min_pulse_prev = inc_min;
    hr_pulse_prev  = inc_hr;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) passed++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  task automatic clear_logs();
    min_q.delete();
    hr_q.delete();
    nr_hr_q.delete();
    min_rise_q.delete();
    min_fall = -1;
    both_cnt = 0;
  endtask

  initial begin
    int p, r, t0, t1;
    reset = 1'b0;
    key_min_n = 1'b1;
    key_hr_n = 1'b1;
    nr_key_min_n = 1'b1;
    nr_key_hr_n = 1'b1;
    tick(3);
    check("rst_inc_min", int'(inc_min), 0);
    check("rst_inc_hr", int'(inc_hr), 0);
    check("rst_min_held", int'(min_held), 0);
    check("rst_hr_held", int'(hr_held), 0);
    reset = 1'b1;
    tick(20);

    // Clean press, 30 clocks
    clear_logs();
    p = cyc + 1;
    key_min_n = 1'b0;
    tick(30);
    r = cyc + 1;
    key_min_n = 1'b1;
    tick(20);
    check("clean_pulse_count", min_q.size(), 1);
    t0 = (min_q.size() > 0) ? min_q[0] : -1;
    check_rng("clean_pulse_time", t0 - p, 11, 13);
    t1 = (min_rise_q.size() > 0) ? min_rise_q[0] : -1;
    check("clean_held_rise", t1, t0);
    check_rng("clean_held_fall", min_fall - r, 11, 13);
    check("clean_held_end", int'(min_held), 0);

    // Glitchy press: 5 low, 2 high, 3 low
    clear_logs();
    key_min_n = 1'b0; tick(5);
    key_min_n = 1'b1; tick(2);
    key_min_n = 1'b0; tick(3);
    key_min_n = 1'b1; tick(30);
    check("glitch_pulses", min_q.size(), 0);
    check("glitch_held", min_rise_q.size(), 0);

    // Valid press followed by release bounce
    clear_logs();
    key_min_n = 1'b0;
    tick(30);
    for (int i = 0; i < 5; i++) begin
      key_min_n = 1'b1; tick(2);
      key_min_n = 1'b0; tick(2);
    end
    key_min_n = 1'b1;
    tick(30);
    check("bounce_pulses", min_q.size(), 1);
    check("bounce_held_end", int'(min_held), 0);

    // Hours held 200 clocks, with and without auto-repeat
    clear_logs();
    p = cyc + 1;
    key_hr_n = 1'b0;
    nr_key_hr_n = 1'b0;
    tick(200);
    key_hr_n = 1'b1;
    nr_key_hr_n = 1'b1;
    tick(30);
    check("repeat_count", hr_q.size(), 8);
    t0 = (hr_q.size() > 0) ? hr_q[0] : -1;
    check_rng("repeat_first", t0 - p, 11, 13);
    for (int i = 1; i < hr_q.size(); i++) begin
      check($sformatf("repeat_gap%0d", i), hr_q[i] - hr_q[i-1], (i == 1) ? int'(HC) : int'(RC));
    end
    check("norepeat_count", nr_hr_q.size(), 1);
    check("repeat_held_end", int'(hr_held), 0);
    check("norepeat_held_end", int'(nr_hr_held), 0);

    // Both keys pressed together
    clear_logs();
    key_min_n = 1'b0;
    key_hr_n = 1'b0;
    tick(30);
    key_min_n = 1'b1;
    key_hr_n = 1'b1;
    tick(30);
    check("both_min_count", min_q.size(), 1);
    check("both_hr_count", hr_q.size(), 1);
    check("both_same_cycle", both_cnt, 1);

    // Key held low through reset release
    reset = 1'b0;
    key_min_n = 1'b0;
    tick(3);
    clear_logs();
    reset = 1'b1;
    tick(30);
    check("thru_rst_pulses", min_q.size(), 0);
    check("thru_rst_held", int'(min_held), 0);
    key_min_n = 1'b1;
    tick(10);
    p = cyc + 1;
    key_min_n = 1'b0;
    tick(20);
    check("after_arm_count", min_q.size(), 1);
    t0 = (min_q.size() > 0) ? min_q[0] : -1;
    check_rng("after_arm_time", t0 - p, 11, 13);
    key_min_n = 1'b1;
    tick(20);

    // Reset asserted while in HOLD
    clear_logs();
    key_min_n = 1'b0;
    tick(20);
    check("hold_held_before", int'(min_held), 1);
    #2 reset = 1'b0;
    #1;
    check("hold_rst_held", int'(min_held), 0);
    check("hold_rst_inc", int'(inc_min), 0);
    clear_logs();
    tick(3);
    reset = 1'b1;
    tick(40);
    key_min_n = 1'b1;
    tick(30);
    check("hold_rst_post_pulses", min_q.size(), 0);

    // Reset asserted while in REPEAT, during a repeat pulse
    clear_logs();
    key_hr_n = 1'b0;
    tick(83);
    check("rpt_pulse_before", int'(inc_hr), 1);
    check("rpt_held_before", int'(hr_held), 1);
    #2 reset = 1'b0;
    #1;
    check("rpt_rst_inc_hr", int'(inc_hr), 0);
    check("rpt_rst_hr_held", int'(hr_held), 0);
    check("rpt_rst_inc_min", int'(inc_min), 0);
    check("rpt_rst_min_held", int'(min_held), 0);
    clear_logs();
    tick(3);
    reset = 1'b1;
    tick(40);
    key_hr_n = 1'b1;
    tick(30);
    check("rpt_rst_post_pulses", hr_q.size(), 0);
    check("rpt_rst_post_held", int'(hr_held), 0);

    check("no_back_to_back", b2b_cnt, 0);
    check("nr_min_idle", nr_min_cnt, 0);
    check("nr_min_held_idle", int'(nr_min_held), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
